// File: rtl/retire_unit.sv
// In-order retirement stage: pops the active-list head, maintains the committed
// rename map, releases stale physical tags and replays the map after a mispredict.
module retire_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              al_head_valid,
    input  logic              al_head_done,
    input  logic              al_head_has_dest,
    input  logic [4:0]        al_head_logical,
    input  logic [PHYS_W-1:0] al_head_physical,
    input  logic              al_head_mispredict,
    output logic              al_retire,
    output logic              free_valid,
    output logic [PHYS_W-1:0] free_reg,
    input  logic              free_ready,
    output logic              flush,
    output logic              restore_valid,
    output logic [4:0]        restore_idx,
    output logic [PHYS_W-1:0] restore_phys,
    output logic [31:0]       retire_count
);

    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARCH_REGS - 1);

    typedef enum logic [1:0] {RUN, FLUSH, RESTORE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PHYS_W-1:0] r_map [ARCH_REGS];
    logic [IDX_W-1:0]  r_cnt;
    logic [31:0]       r_retire_count;
    logic              w_retire;
    logic              w_map_wr;

    // Stall a writing instruction until the free list can take its stale tag.
    assign w_retire = rst_n && (r_state == RUN) && al_head_valid && al_head_done &&
                      (!al_head_has_dest || free_ready);
    // r0 keeps its identity mapping; its fresh tag goes straight back to the free list.
    assign w_map_wr = w_retire && al_head_has_dest && (al_head_logical != '0);

    always_comb begin
        w_state_nxt   = r_state;
        al_retire     = w_retire;
        free_valid    = 1'b0;
        free_reg      = '0;
        flush         = 1'b0;
        restore_valid = 1'b0;
        restore_idx   = '0;
        restore_phys  = '0;
        case (r_state)
            RUN: begin
                if (w_retire && al_head_has_dest) begin
                    free_valid = 1'b1;
                    free_reg   = (al_head_logical == '0) ? al_head_physical
                                                         : r_map[al_head_logical];
                end
                if (w_retire && al_head_mispredict) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                flush       = 1'b1;
                w_state_nxt = RESTORE;
            end
            RESTORE: begin
                restore_valid = 1'b1;
                restore_idx   = r_cnt;
                restore_phys  = r_map[r_cnt];
                if (r_cnt == LAST_IDX) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_cnt          <= '0;
            r_retire_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RESTORE) r_cnt <= r_cnt + IDX_W'(1);
            else                    r_cnt <= '0;
            if (w_retire) r_retire_count <= r_retire_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) r_map[i] <= PHYS_W'(i);
        end else if (w_map_wr) begin
            r_map[al_head_logical] <= al_head_physical;
        end
    end

    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit: expected frees and restore beats are queued
// from a reference map when stimulus is driven and compared as the DUT emits them.
module tb_retire_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       al_head_valid = 1'b0, al_head_done = 1'b0, al_head_has_dest = 1'b0;
    logic [4:0] al_head_logical = '0;
    logic [5:0] al_head_physical = '0;
    logic       al_head_mispredict = 1'b0;
    logic       al_retire, free_valid, free_ready = 1'b1, flush, restore_valid;
    logic [5:0] free_reg, restore_phys;
    logic [4:0] restore_idx;
    logic [31:0] retire_count;

    typedef struct {logic fv; logic [5:0] fr;} free_t;
    typedef struct {logic [4:0] idx; logic [5:0] ph;} rst_t;

    free_t      free_q[$];
    rst_t       rest_q[$];
    logic [5:0] m_map [32];
    logic [31:0] m_cnt;
    int         n_cmp = 0, n_err = 0;

    retire_unit #(.ARCH_REGS(32), .PHYS_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .al_head_valid(al_head_valid), .al_head_done(al_head_done),
        .al_head_has_dest(al_head_has_dest), .al_head_logical(al_head_logical),
        .al_head_physical(al_head_physical), .al_head_mispredict(al_head_mispredict),
        .al_retire(al_retire), .free_valid(free_valid), .free_reg(free_reg),
        .free_ready(free_ready), .flush(flush), .restore_valid(restore_valid),
        .restore_idx(restore_idx), .restore_phys(restore_phys), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = 6'(i);
        m_cnt = '0;
    endtask

    task automatic drive_head(input logic hd, input logic [4:0] lg, input logic [5:0] ph,
                              input logic mp);
        al_head_valid = 1'b1; al_head_done = 1'b1; al_head_has_dest = hd;
        al_head_logical = lg; al_head_physical = ph; al_head_mispredict = mp;
    endtask

    // Queue the expected release, present the head, wait for the pop and check it.
    task automatic retire_one(input logic hd, input logic [4:0] lg, input logic [5:0] ph,
                              input logic mp);
        free_t e, g;
        bit    seen = 0;
        e.fv = hd;
        e.fr = !hd ? 6'd0 : (lg == 0) ? ph : m_map[lg];
        free_q.push_back(e);
        @(negedge clk);
        free_ready = 1'b1;
        drive_head(hd, lg, ph, mp);
        for (int k = 0; k < 40 && !seen; k++) begin
            #1;
            if (al_retire) seen = 1;
            else @(negedge clk);
        end
        chk("retire_seen", 32'(seen), 32'd1);
        g = free_q.pop_front();
        if (seen) begin
            chk("free_valid", 32'(free_valid), 32'(g.fv));
            if (g.fv) chk("free_reg", 32'(free_reg), 32'(g.fr));
            @(posedge clk);
            if (hd && lg != 0) m_map[lg] = ph;
            m_cnt = m_cnt + 32'd1;
            #1;
            al_head_valid = 1'b0;
            chk("retire_count", retire_count, m_cnt);
        end
    endtask

    // Called right after a mispredict retires: check flush, then every restore beat.
    task automatic check_flush_restore(input int stop_at);
        rst_t e;
        @(negedge clk);
        drive_head(1'b1, 5'd3, 6'd60, 1'b0);
        #1;
        chk("flush_pulse", 32'(flush), 32'd1);
        chk("flush_no_retire", 32'(al_retire), 32'd0);
        chk("flush_no_free", 32'(free_valid), 32'd0);
        for (int i = 0; i < 32; i++) rest_q.push_back('{idx: 5'(i), ph: m_map[i]});
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            #1;
            e = rest_q.pop_front();
            chk("restore_valid", 32'(restore_valid), 32'd1);
            chk("restore_idx", 32'(restore_idx), 32'(e.idx));
            chk("restore_phys", 32'(restore_phys), 32'(e.ph));
            chk("restore_no_retire", 32'(al_retire | flush), 32'd0);
            if (i == stop_at) begin
                rest_q.delete();
                return;
            end
        end
        @(negedge clk);
        al_head_valid = 1'b0;
        #1;
        chk("restore_done", 32'(restore_valid), 32'd0);
        chk("restore_idx_idle", 32'(restore_idx), 32'd0);
    endtask

    initial begin
        model_reset();
        drive_head(1'b1, 5'd4, 6'd44, 1'b1);
        #12;
        chk("rst_al_retire", 32'(al_retire), 32'd0);
        chk("rst_free_valid", 32'(free_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_restore_valid", 32'(restore_valid), 32'd0);
        chk("rst_count", retire_count, 32'd0);
        @(negedge clk);
        al_head_valid = 1'b0;
        rst_n = 1'b1;

        retire_one(1'b1, 5'd5, 6'd40, 1'b0);
        retire_one(1'b1, 5'd5, 6'd41, 1'b0);
        chk("count_two", retire_count, 32'd2);
        retire_one(1'b0, 5'd9, 6'd50, 1'b0);
        retire_one(1'b1, 5'd0, 6'd33, 1'b0);
        for (int i = 0; i < 10; i++)
            retire_one(1'b1, 5'($urandom_range(0, 31)), 6'($urandom_range(32, 63)), 1'b0);

        retire_one(1'b0, 5'd0, 6'd0, 1'b1);
        check_flush_restore(99);
        retire_one(1'b1, 5'd5, 6'd42, 1'b0);

        // free list backpressure
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        free_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_head(1'b1, 5'd6, 6'd45, 1'b0);
            #1;
            chk("stall_retire", 32'(al_retire), 32'd0);
            chk("stall_free", 32'(free_valid), 32'd0);
        end
        retire_one(1'b1, 5'd6, 6'd45, 1'b0);
        chk("stall_count", retire_count, 32'd1);

        // reset in the middle of a restore
        retire_one(1'b1, 5'd8, 6'd47, 1'b0);
        retire_one(1'b0, 5'd0, 6'd0, 1'b1);
        check_flush_restore(10);
        rst_n = 1'b0;
        #1;
        chk("abort_restore", 32'(restore_valid), 32'd0);
        chk("abort_retire", 32'(al_retire), 32'd0);
        chk("abort_count", retire_count, 32'd0);
        model_reset();
        @(negedge clk);
        al_head_valid = 1'b0;
        rst_n = 1'b1;
        retire_one(1'b1, 5'd8, 6'd48, 1'b0);
        chk("abort_count_after", retire_count, 32'd1);

        // counter wrap, preloaded close to the boundary
        @(negedge clk);
        dut.r_retire_count = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        retire_one(1'b0, 5'd1, 6'd1, 1'b0);
        retire_one(1'b0, 5'd1, 6'd1, 1'b0);
        chk("wrap_zero", retire_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
